// File: rtl/mdu_div.sv
// Multi-cycle RV32M divide unit (DIV/DIVU/REM/REMU), radix-2 restoring, one quotient bit per clock.
// Divide-by-zero and signed overflow resolve on the accept edge; everything else takes XLEN iterations.
module mdu_div #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    state_t          r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]      r_op;
    logic            r_sign_a;
    logic            r_sign_b;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_quo;
    logic [XLEN:0]   r_dvs;
    logic            r_busy;
    logic            r_valid;
    logic [XLEN-1:0] r_result;

    // Operand preparation on the accept edge.
    logic            w_signed;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_abs;
    logic [XLEN-1:0] w_b_abs;
    logic            w_div_zero;
    logic            w_ovf;
    logic [XLEN-1:0] w_special_res;

    assign w_signed      = ~op_i[0];
    assign w_a_neg       = w_signed & dividend_i[XLEN-1];
    assign w_b_neg       = w_signed & divisor_i[XLEN-1];
    assign w_a_abs       = w_a_neg ? -dividend_i : dividend_i;
    assign w_b_abs       = w_b_neg ? -divisor_i : divisor_i;
    assign w_div_zero    = (divisor_i == '0);
    assign w_ovf         = w_signed & (dividend_i == MIN_NEG) & (divisor_i == '1);
    assign w_special_res = w_div_zero ? (op_i[1] ? dividend_i : '1)
                                      : (op_i[1] ? '0 : dividend_i);

    // One restoring step: the divisor is XLEN+1 bits wide, so the compare sees the full
    // shifted remainder and the low XLEN bits of the difference are exact whenever it is kept.
    logic [XLEN:0]   w_shift;
    logic            w_ge;
    logic [XLEN-1:0] w_diff;
    logic [XLEN-1:0] w_rem_next;
    logic [XLEN-1:0] w_quo_next;
    logic            w_neg_q;
    logic            w_neg_r;
    logic [XLEN-1:0] w_final;

    assign w_shift    = {r_rem, r_quo[XLEN-1]};
    assign w_ge       = (w_shift >= r_dvs);
    assign w_diff     = w_shift[XLEN-1:0] - r_dvs[XLEN-1:0];
    assign w_rem_next = w_ge ? w_diff : w_shift[XLEN-1:0];
    assign w_quo_next = {r_quo[XLEN-2:0], w_ge};
    assign w_neg_q    = ~r_op[0] & (r_sign_a ^ r_sign_b);
    assign w_neg_r    = ~r_op[0] & r_sign_a;
    assign w_final    = r_op[1] ? (w_neg_r ? -w_rem_next : w_rem_next)
                                : (w_neg_q ? -w_quo_next : w_quo_next);

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_op     <= '0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvs    <= '0;
            r_busy   <= 1'b0;
            r_valid  <= 1'b0;
            r_result <= '0;
        end else if (flush_i) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                    if (start_i) begin
                        r_op     <= op_i;
                        r_sign_a <= dividend_i[XLEN-1];
                        r_sign_b <= divisor_i[XLEN-1];
                        r_quo    <= w_a_abs;
                        r_dvs    <= {1'b0, w_b_abs};
                        r_rem    <= '0;
                        r_cnt    <= '0;
                        if (w_div_zero || w_ovf) begin
                            r_result <= w_special_res;
                            r_state  <= S_DONE;
                            r_valid  <= 1'b1;
                        end else begin
                            r_state <= S_CALC;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                S_CALC: begin
                    r_rem <= w_rem_next;
                    r_quo <= w_quo_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_CNT) begin
                        r_result <= w_final;
                        r_state  <= S_DONE;
                        r_busy   <= 1'b0;
                        r_valid  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o   = r_busy;
    assign valid_o  = r_valid;
    assign result_o = r_result;

endmodule
